// File: rtl/mole_game_engine.sv
// Whack-a-mole engine: random one-hot mole, shrinking hit window, BCD score/high score on a 4-digit scan.
// Outputs registered; one mole per round; no flow control (switches sampled every clk).
module mole_game_engine #(
    parameter int N_MOLES    = 16,
    parameter int T_INIT     = 15_000_000,
    parameter int T_MIN      = 500_000,
    parameter int SHRINK_PCT = 95,
    parameter int END_HOLD   = 50_000_000,
    parameter int SCAN_DIV   = 8192
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] led,
    output logic [6:0]         seg,
    output logic [7:0]         an,
    output logic               game_over
);
    typedef enum logic [1:0] {IDLE, ARM, WAIT_HIT, END} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t              state, state_nxt;
    logic                start_q, start_prev, start_edge;
    logic [15:0]         lfsr;
    logic [3:0]          target, cand, tgt_nxt;
    logic                cand_ok, hit, miss, timeout;
    logic [N_MOLES-1:0]  tgt_onehot, led_nxt;
    logic                game_over_nxt;
    logic [31:0]         window, timer, window_shr;
    logic [63:0]         shrink_prod, shrink_div;
    logic [3:0]          score_lo, score_hi, high_lo, high_hi;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          scan_idx, scan_idx_nxt;
    logic [7:0]          an_nxt;
    logic [3:0]          digit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_q    <= start;
            start_prev <= start_q;
        end
    end
    assign start_edge = start_q & ~start_prev;

    // Candidate must be a real mole and differ from the last one, else ARM retries.
    assign cand       = lfsr[3:0];
    assign cand_ok    = ({28'd0, cand} < 32'(N_MOLES)) && (cand != target);
    assign tgt_onehot = N_MOLES'(1) << target;
    assign hit        = (sw == tgt_onehot);
    assign miss       = |(sw & ~tgt_onehot);
    assign timeout    = (timer == 32'd0);

    assign shrink_prod = {32'd0, window} * 64'(SHRINK_PCT);
    assign shrink_div  = shrink_prod / 64'd100;
    assign window_shr  = (shrink_div < 64'(T_MIN)) ? 32'(T_MIN) : shrink_div[31:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_edge) state_nxt = ARM;
            ARM:      if (sw == '0 && cand_ok) state_nxt = WAIT_HIT;
            WAIT_HIT: if (hit) state_nxt = ARM;
                      else if (miss || timeout) state_nxt = END;
            END:      if (timeout) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tgt_nxt       = (state == ARM) ? cand : target;
        led_nxt       = '0;
        game_over_nxt = 1'b0;
        case (state_nxt)
            WAIT_HIT: led_nxt = N_MOLES'(1) << tgt_nxt;
            END: begin
                led_nxt       = '1;
                game_over_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // In END the timer is reused as the all-LEDs hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            target   <= 4'd0;
            window   <= 32'(T_INIT);
            timer    <= 32'd0;
            score_lo <= 4'd0;
            score_hi <= 4'd0;
            high_lo  <= 4'd0;
            high_hi  <= 4'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            case (state)
                IDLE: if (start_edge) begin
                    score_lo <= 4'd0;
                    score_hi <= 4'd0;
                    window   <= 32'(T_INIT);
                end
                ARM: if (state_nxt == WAIT_HIT) begin
                    target <= cand;
                    timer  <= window;
                end
                WAIT_HIT: begin
                    if (hit) begin
                        window <= window_shr;
                        if ({score_hi, score_lo} != 8'h99) begin
                            if (score_lo == 4'd9) begin
                                score_lo <= 4'd0;
                                score_hi <= score_hi + 4'd1;
                            end else begin
                                score_lo <= score_lo + 4'd1;
                            end
                        end
                    end else if (state_nxt == END) begin
                        timer <= 32'(END_HOLD - 1);
                        if ({score_hi, score_lo} > {high_hi, high_lo}) begin
                            high_hi <= score_hi;
                            high_lo <= score_lo;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                END: if (!timeout) timer <= timer - 32'd1;
                default: ;
            endcase
        end
    end

    assign scan_idx_nxt = (scan_cnt == SCAN_W'(SCAN_DIV - 1)) ? scan_idx + 2'd1 : scan_idx;

    always_comb begin
        an_nxt = 8'hFE;
        digit  = score_lo;
        case (scan_idx_nxt)
            2'd0: begin an_nxt = 8'hFE; digit = score_lo; end
            2'd1: begin an_nxt = 8'hFD; digit = score_hi; end
            2'd2: begin an_nxt = 8'hBF; digit = high_lo;  end
            2'd3: begin an_nxt = 8'h7F; digit = high_hi;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            scan_idx  <= 2'd0;
            an        <= 8'hFE;
            seg       <= 7'b0000001;
            led       <= '0;
            game_over <= 1'b0;
        end else begin
            scan_cnt  <= (scan_cnt == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt + SCAN_W'(1);
            scan_idx  <= scan_idx_nxt;
            an        <= an_nxt;
            seg       <= seg_code(digit);
            led       <= led_nxt;
            game_over <= game_over_nxt;
        end
    end
endmodule

// File: tb/tb_mole_game_engine.sv
module tb_mole_game_engine;
    localparam int NM = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NM-1:0] sw = '0;
    logic [NM-1:0] led;
    logic [6:0]    seg;
    logic [7:0]    an;
    logic          game_over;

    int checks = 0;
    int errors = 0;
    int exp_win_q[$];
    int model_win = 100, model_score = 0, model_high = 0, prev_tgt = -1;
    logic [3:0] disp [4];

    mole_game_engine #(
        .N_MOLES(8), .T_INIT(100), .T_MIN(20), .SHRINK_PCT(50), .END_HOLD(10), .SCAN_DIV(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sw(sw),
        .led(led), .seg(seg), .an(an), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] seg2dig(input logic [6:0] s);
        case (s)
            7'b0000001: seg2dig = 4'd0;
            7'b1001111: seg2dig = 4'd1;
            7'b0010010: seg2dig = 4'd2;
            7'b0000110: seg2dig = 4'd3;
            7'b1001100: seg2dig = 4'd4;
            7'b0100100: seg2dig = 4'd5;
            7'b0100000: seg2dig = 4'd6;
            7'b0001111: seg2dig = 4'd7;
            7'b0000000: seg2dig = 4'd8;
            7'b0000100: seg2dig = 4'd9;
            default:    seg2dig = 4'hF;
        endcase
    endfunction

    function automatic logic [15:0] exp_disp();
        exp_disp = {4'(model_high / 10), 4'(model_high % 10), 4'(model_score / 10), 4'(model_score % 10)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_score = 0;
        model_win   = 100;
        prev_tgt    = -1;
    endtask

    task automatic wait_target(output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (led != '0 && !game_over) begin
                for (int b = 0; b < NM; b++) if (led[b]) t = b;
                break;
            end
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL wait_target: led=%b, required a single lit mole", led);
        end
    endtask

    task automatic wait_level(input logic lvl);
        for (int i = 0; i < 400 && game_over !== lvl; i++) @(negedge clk);
        if (game_over !== lvl) begin
            checks++; errors++;
            $display("FAIL wait_game_over: game_over=%b, required %b", game_over, lvl);
        end
    endtask

    task automatic do_hit(input int t);
        int w;
        sw = NM'(1) << t;
        if (model_score < 99) model_score++;
        model_win = (model_win * 50 / 100 < 20) ? 20 : model_win * 50 / 100;
        exp_win_q.push_back(model_win);
        @(negedge clk);
        checks++;
        if (led !== '0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL hit_to_arm: led=%b game_over=%b, required led=0 game_over=0", led, game_over);
        end
        sw = '0;
        w = exp_win_q.pop_front();
        checks++;
        if (dut.window !== 32'(w)) begin
            errors++;
            $display("FAIL window: got %0d, required %0d", dut.window, w);
        end
    endtask

    task automatic read_display();
        for (int i = 0; i < 4; i++) disp[i] = 4'hE;
        repeat (20) begin
            @(negedge clk);
            case (an)
                8'hFE: disp[0] = seg2dig(seg);
                8'hFD: disp[1] = seg2dig(seg);
                8'hBF: disp[2] = seg2dig(seg);
                8'h7F: disp[3] = seg2dig(seg);
                default: ;
            endcase
        end
    endtask

    task automatic finish_game();
        wait_level(1'b1);
        if (model_score > model_high) model_high = model_score;
        wait_level(1'b0);
        read_display();
        checks++;
        if ({disp[3], disp[2], disp[1], disp[0]} !== exp_disp()) begin
            errors++;
            $display("FAIL display: got %h, required %h", {disp[3], disp[2], disp[1], disp[0]}, exp_disp());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sw = '0;
        tick(3);
        reset = 1'b0;
        checks++;
        if (led !== '0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: led=%b game_over=%b, required 0 0", led, game_over);
        end
        checks++;
        if (an !== 8'hFE || seg !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_display: an=%b seg=%b, required 11111110 0000001", an, seg);
        end
        checks++;
        if (dut.window !== 32'd100) begin
            errors++;
            $display("FAIL reset_window: got %0d, required 100", dut.window);
        end
    endtask

    task automatic test_timeout();
        int t, n, cnt;
        start_game();
        wait_target(t);
        n = 0;
        while (n < 200 && !game_over) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 101) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, required 101", n);
        end
        cnt = 0;
        while (cnt < 50 && game_over && led === '1) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 10) begin
            errors++;
            $display("FAIL end_hold: got %0d cycles of all-lit, required 10", cnt);
        end
        checks++;
        if (led !== '0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: led=%b game_over=%b, required 0 0", led, game_over);
        end
        read_display();
        checks++;
        if ({disp[3], disp[2], disp[1], disp[0]} !== exp_disp()) begin
            errors++;
            $display("FAIL timeout_display: got %h, required %h", {disp[3], disp[2], disp[1], disp[0]}, exp_disp());
        end
    endtask

    task automatic test_hits();
        int t;
        start_game();
        for (int k = 0; k < 4; k++) begin
            wait_target(t);
            checks++;
            if (!$onehot(led) || t < 0 || t >= NM || t == prev_tgt) begin
                errors++;
                $display("FAIL target_%0d: led=%b prev=%0d, required one-hot new target", k, led, prev_tgt);
            end
            prev_tgt = t;
            if (k < 3) do_hit(t);
        end
        finish_game();
    endtask

    task automatic test_miss();
        int t;
        start_game();
        wait_target(t);
        do_hit(t);
        wait_target(t);
        sw = NM'(1) << ((t + 1) % NM);
        @(negedge clk);
        sw = '0;
        checks++;
        if (game_over !== 1'b1 || led !== '1) begin
            errors++;
            $display("FAIL miss_end: game_over=%b led=%b, required 1 11111111", game_over, led);
        end
        finish_game();
    endtask

    task automatic test_hit_at_zero();
        int t;
        start_game();
        wait_target(t);
        tick(100);
        checks++;
        if (dut.timer !== 32'd0 || led !== NM'(1) << t) begin
            errors++;
            $display("FAIL zero_setup: timer=%0d led=%b, required 0 and target lit", dut.timer, led);
        end
        do_hit(t);
        wait_target(t);
        finish_game();
    endtask

    task automatic test_start_ignored();
        int t, bad;
        start_game();
        wait_target(t);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        checks++;
        if (led !== NM'(1) << t || game_over !== 1'b0) begin
            errors++;
            $display("FAIL start_in_wait: led=%b game_over=%b, required target held", led, game_over);
        end
        wait_level(1'b1);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_level(1'b0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (led !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL start_in_end: %0d cycles with led lit, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        logic [7:0] an_exp [4] = '{8'hFE, 8'hFD, 8'hBF, 8'h7F};
        start_game();
        for (int k = 0; k < 5; k++) begin
            wait_target(t);
            do_hit(t);
        end
        wait_target(t);
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_score = 0; model_high = 0; model_win = 100;
        checks++;
        if (led !== '0 || game_over !== 1'b0 || dut.window !== 32'd100) begin
            errors++;
            $display("FAIL reset_mid: led=%b game_over=%b window=%0d, required 0 0 100", led, game_over, dut.window);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (an !== an_exp[i / 4] || seg !== 7'b0000001) begin
                errors++;
                $display("FAIL scan_%0d: an=%b seg=%b, required %b 0000001", i, an, seg, an_exp[i / 4]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timeout();
        test_hits();
        test_miss();
        test_hit_at_zero();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
